bids_multi: RTL and testbench

Parametrised N-bidder sealed-round auction controller, the next generation of the three-bidder bids22 engine. A controller loads bidder balances, mask, bid charge and cooldown timer while unlocked, then locks the block with a key. It runs bid rounds framed by `C_start` and reports the winner as a one-hot vector plus the winning amount. It sits behind the auction host interface, one instance per auction channel.

---
 rtl/bids_multi.sv | 277 +++++++++++++++++++++++++++
 tb/tb_bids_multi.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bids_multi.sv
// -----------------------------------------------------------------------------
// bids_multi : N-bidder sealed-round auction controller.
//
// The host loads balances, mask, bid charge and cooldown timer while the block
// is unlocked, then locks it with a key. Rounds are framed by C_start. At the
// end of each round the largest standing bid wins, with ties going to the
// lowest bidder index.
//
// Ports
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   C_op, C_data  : controller opcode and operand
//   C_addr        : bidder index used by LOAD
//   C_start       : round framing, high for the whole round
//   bid, retract  : per-bidder strobes
//   bidAmt        : packed bid amounts, bidder i at [i*DATAWIDTH +: DATAWIDTH]
//   ready         : block is LOCKED and can start a round
//   err           : registered controller error code
//   roundOver     : one-cycle pulse while in ROUNDOVER
//   maxBid, win   : winning amount and one-hot winner
//   balance       : packed current balances
//   bidErr        : packed registered per-bidder error codes (2 bits each)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// UNLOCKED  | configuration opcodes accepted
// LOCKED    | configuration frozen, waiting for C_start or UNLOCK
// COOLDOWN  | wrong key given, BADKEY reported until the counter expires
// ROUND     | bids and retracts processed every cycle
// ROUNDOVER | one cycle: winner resolved, standing bids cleared
// -----------------------------------------------------------------------------
module bids_multi #(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 4,
    parameter int IDXW       = $clog2(NUMBIDDERS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [3:0]                      C_op,
    input  logic [DATAWIDTH-1:0]            C_data,
    input  logic [IDXW-1:0]                 C_addr,
    input  logic                            C_start,
    input  logic [NUMBIDDERS-1:0]           bid,
    input  logic [NUMBIDDERS-1:0]           retract,
    input  logic [NUMBIDDERS*DATAWIDTH-1:0] bidAmt,
    output logic                            ready,
    output logic [2:0]                      err,
    output logic                            roundOver,
    output logic [DATAWIDTH-1:0]            maxBid,
    output logic [NUMBIDDERS-1:0]           win,
    output logic [NUMBIDDERS*DATAWIDTH-1:0] balance,
    output logic [NUMBIDDERS*2-1:0]         bidErr
);

    typedef enum logic [2:0] {
        S_UNLOCKED,
        S_LOCKED,
        S_COOLDOWN,
        S_ROUND,
        S_ROUNDOVER
    } state_t;

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_UNLOCK   = 4'd1;
    localparam logic [3:0] OP_LOCK     = 4'd2;
    localparam logic [3:0] OP_LOAD     = 4'd3;
    localparam logic [3:0] OP_SETMASK  = 4'd4;
    localparam logic [3:0] OP_SETTIMER = 4'd5;
    localparam logic [3:0] OP_SETCHRG  = 4'd6;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BADKEY   = 3'd1;
    localparam logic [2:0] ERR_UNLOCKED = 3'd2;
    localparam logic [2:0] ERR_CSTART   = 3'd3;
    localparam logic [2:0] ERR_INVOP    = 3'd4;
    localparam logic [2:0] ERR_LOCKED   = 3'd5;

    localparam logic [1:0] BE_NONE  = 2'd0;
    localparam logic [1:0] BE_FUNDS = 2'd1;
    localparam logic [1:0] BE_INVAL = 2'd2;

    state_t                  state_q,   state_d;
    logic [DATAWIDTH-1:0]    key_q,     key_d;
    logic [DATAWIDTH-1:0]    timer_q,   timer_d;
    logic [DATAWIDTH-1:0]    charge_q,  charge_d;
    logic [NUMBIDDERS-1:0]   mask_q,    mask_d;
    logic [DATAWIDTH-1:0]    cnt_q,     cnt_d;
    logic [2:0]              err_q,     err_d;
    logic [DATAWIDTH-1:0]    maxbid_q,  maxbid_d;
    logic [NUMBIDDERS-1:0]   win_q,     win_d;
    logic [DATAWIDTH-1:0]    balance_q [NUMBIDDERS];
    logic [DATAWIDTH-1:0]    balance_d [NUMBIDDERS];
    logic [DATAWIDTH-1:0]    lastbid_q [NUMBIDDERS];
    logic [DATAWIDTH-1:0]    lastbid_d [NUMBIDDERS];
    logic [1:0]              biderr_q  [NUMBIDDERS];
    logic [1:0]              biderr_d  [NUMBIDDERS];

    logic [DATAWIDTH-1:0]    max_amt_c;
    logic [NUMBIDDERS-1:0]   max_win_c;
    logic [DATAWIDTH:0]      bid_sum;

    // Strict greater-than keeps the first (lowest index) bidder on a tie and
    // leaves win at zero when every standing bid is zero.
    always_comb begin
        max_amt_c = '0;
        max_win_c = '0;
        for (int i = 0; i < NUMBIDDERS; i++) begin
            if (lastbid_q[i] > max_amt_c) begin
                max_amt_c    = lastbid_q[i];
                max_win_c    = '0;
                max_win_c[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        timer_d  = timer_q;
        charge_d = charge_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        err_d    = ERR_NONE;
        maxbid_d = maxbid_q;
        win_d    = win_q;
        bid_sum  = '0;
        for (int i = 0; i < NUMBIDDERS; i++) begin
            balance_d[i] = balance_q[i];
            lastbid_d[i] = lastbid_q[i];
            biderr_d[i]  = BE_NONE;
        end

        case (state_q)
            S_UNLOCKED: begin
                if (C_start) begin
                    err_d = ERR_CSTART;
                end else begin
                    case (C_op)
                        OP_NOP:      ;
                        OP_UNLOCK:   err_d = ERR_UNLOCKED;
                        OP_LOCK: begin
                            key_d   = C_data;
                            state_d = S_LOCKED;
                        end
                        OP_LOAD: begin
                            if (int'(C_addr) < NUMBIDDERS) begin
                                balance_d[C_addr] = C_data;
                            end else begin
                                err_d = ERR_INVOP;
                            end
                        end
                        OP_SETMASK:  mask_d   = C_data[NUMBIDDERS-1:0];
                        OP_SETTIMER: timer_d  = C_data;
                        OP_SETCHRG:  charge_d = C_data;
                        default:     err_d    = ERR_INVOP;
                    endcase
                end
            end

            S_LOCKED: begin
                if (C_start) begin
                    state_d  = S_ROUND;
                    maxbid_d = '0;
                    win_d    = '0;
                end else begin
                    case (C_op)
                        OP_NOP: ;
                        OP_UNLOCK: begin
                            if (C_data == key_q) begin
                                state_d = S_UNLOCKED;
                            end else begin
                                cnt_d   = timer_q;
                                err_d   = ERR_BADKEY;
                                state_d = S_COOLDOWN;
                            end
                        end
                        OP_LOCK: err_d = ERR_LOCKED;
                        default: err_d = ERR_INVOP;
                    endcase
                end
            end

            // err is registered, so BADKEY is driven whenever the next state
            // is still COOLDOWN; that makes it cover exactly the COOLDOWN cycles.
            S_COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = S_LOCKED;
                end else begin
                    cnt_d = cnt_q - DATAWIDTH'(1);
                    err_d = ERR_BADKEY;
                end
            end

            S_ROUND: begin
                for (int i = 0; i < NUMBIDDERS; i++) begin
                    if (bid[i]) begin
                        if (!mask_q[i]) begin
                            biderr_d[i] = BE_INVAL;
                        end else begin
                            // One extra bit so amount + charge cannot wrap.
                            bid_sum = {1'b0, bidAmt[i*DATAWIDTH +: DATAWIDTH]} +
                                      {1'b0, charge_q};
                            if (bid_sum > {1'b0, balance_q[i]}) begin
                                biderr_d[i] = BE_FUNDS;
                            end else begin
                                balance_d[i] = balance_q[i] - bid_sum[DATAWIDTH-1:0];
                                lastbid_d[i] = bidAmt[i*DATAWIDTH +: DATAWIDTH];
                            end
                        end
                    end else if (retract[i]) begin
                        lastbid_d[i] = '0;
                    end
                end
                if (!C_start) begin
                    state_d = S_ROUNDOVER;
                end
            end

            S_ROUNDOVER: begin
                maxbid_d = max_amt_c;
                win_d    = max_win_c;
                for (int i = 0; i < NUMBIDDERS; i++) begin
                    lastbid_d[i] = '0;
                end
                state_d = S_LOCKED;
            end

            default: state_d = S_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_UNLOCKED;
            key_q    <= '0;
            timer_q  <= DATAWIDTH'(15);
            charge_q <= DATAWIDTH'(1);
            mask_q   <= '1;
            cnt_q    <= '0;
            err_q    <= ERR_NONE;
            maxbid_q <= '0;
            win_q    <= '0;
            for (int i = 0; i < NUMBIDDERS; i++) begin
                balance_q[i] <= '0;
                lastbid_q[i] <= '0;
                biderr_q[i]  <= BE_NONE;
            end
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            timer_q  <= timer_d;
            charge_q <= charge_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            maxbid_q <= maxbid_d;
            win_q    <= win_d;
            for (int i = 0; i < NUMBIDDERS; i++) begin
                balance_q[i] <= balance_d[i];
                lastbid_q[i] <= lastbid_d[i];
                biderr_q[i]  <= biderr_d[i];
            end
        end
    end

    assign ready     = (state_q == S_LOCKED);
    assign roundOver = (state_q == S_ROUNDOVER);
    assign err       = err_q;
    // The result is visible during ROUNDOVER itself and held afterwards.
    assign maxBid    = roundOver ? max_amt_c : maxbid_q;
    assign win       = roundOver ? max_win_c : win_q;

    for (genvar g = 0; g < NUMBIDDERS; g++) begin : g_pack
        assign balance[g*DATAWIDTH +: DATAWIDTH] = balance_q[g];
        assign bidErr[g*2 +: 2]                  = biderr_q[g];
    end

endmodule

// File: tb/tb_bids_multi.sv
`timescale 1ns/1ps
module tb_bids_multi;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       C_op;
    logic [DW-1:0]    C_data;
    logic [IW-1:0]    C_addr;
    logic             C_start;
    logic [N-1:0]     bid, retract;
    logic [N*DW-1:0]  bidAmt;
    logic             ready;
    logic [2:0]       err;
    logic             roundOver;
    logic [DW-1:0]    maxBid;
    logic [N-1:0]     win;
    logic [N*DW-1:0]  balance;
    logic [2*N-1:0]   bidErr;

    // five-bidder instance, used where an out-of-range LOAD address is representable
    logic [3:0]       op5;
    logic [DW-1:0]    data5;
    logic [2:0]       addr5;
    logic             ready5, roundOver5;
    logic [2:0]       err5;
    logic [DW-1:0]    maxBid5;
    logic [4:0]       win5;
    logic [5*DW-1:0]  balance5;
    logic [9:0]       bidErr5;

    bids_multi #(.DATAWIDTH(DW), .NUMBIDDERS(N)) dut (
        .clk(clk), .reset(reset), .C_op(C_op), .C_data(C_data), .C_addr(C_addr),
        .C_start(C_start), .bid(bid), .retract(retract), .bidAmt(bidAmt),
        .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid),
        .win(win), .balance(balance), .bidErr(bidErr));

    bids_multi #(.DATAWIDTH(DW), .NUMBIDDERS(5)) dut5 (
        .clk(clk), .reset(reset), .C_op(op5), .C_data(data5), .C_addr(addr5),
        .C_start(1'b0), .bid(5'd0), .retract(5'd0), .bidAmt('0),
        .ready(ready5), .err(err5), .roundOver(roundOver5), .maxBid(maxBid5),
        .win(win5), .balance(balance5), .bidErr(bidErr5));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        C_op = 4'd0; C_data = '0; C_addr = '0; C_start = 1'b0;
        bid = '0; retract = '0; bidAmt = '0;
    endtask

    task automatic cop(input logic [3:0] op, input logic [DW-1:0] d, input logic [IW-1:0] a,
                       input logic [2:0] exp_err, input string name);
        C_op = op; C_data = d; C_addr = a;
        step();
        chk(name, err, exp_err);
        C_op = 4'd0; C_data = '0; C_addr = '0;
    endtask

    task automatic start_round(input string tag);
        C_start = 1'b1;
        step();
        chk({tag, "_rdy_in_round"}, ready, 0);
        chk({tag, "_max_cleared"}, maxBid, 0);
        chk({tag, "_win_cleared"}, win, 0);
    endtask

    task automatic bid_cycle(input logic [N-1:0] b, input logic [N-1:0] r, input logic [N*DW-1:0] amts);
        C_start = 1'b1; bid = b; retract = r; bidAmt = amts;
        step();
        bid = '0; retract = '0; bidAmt = '0;
    endtask

    task automatic end_round(input logic [DW-1:0] emax, input logic [N-1:0] ewin, input string tag);
        C_start = 1'b0; bid = '0; retract = '0;
        step();
        chk({tag, "_roundOver"}, roundOver, 1);
        chk({tag, "_maxBid"}, maxBid, emax);
        chk({tag, "_win"}, win, ewin);
        step();
        chk({tag, "_roundOver_off"}, roundOver, 0);
        chk({tag, "_ready_after"}, ready, 1);
        chk({tag, "_maxBid_hold"}, maxBid, emax);
        chk({tag, "_win_hold"}, win, ewin);
    endtask

    // Wrong key while LOCKED; garbage is driven during COOLDOWN to show it is ignored.
    task automatic cooldown(input logic [DW-1:0] badkey, input int exp_n, input string tag);
        int n = 0;
        C_op = 4'd1; C_data = badkey;
        step();
        C_op = 4'd2; C_start = 1'b1;
        while (err == 3'd1 && n < 40) begin
            n++;
            step();
        end
        idle();
        chk({tag, "_badkey_cycles"}, n, exp_n);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_err_after"}, err, 0);
    endtask

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] data;
        logic [IW-1:0] addr;
        logic          cs;
        logic [2:0]    e_err;
        logic          e_rdy;
    } vec_t;

    vec_t vt [15];

    longint     m_bal [N];
    longint     m_last [N];
    longint     m_charge;
    logic [N-1:0] m_mask;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0]   key;
        logic [N-1:0]    bv, rv;
        logic [N*DW-1:0] amts, ebal;
        logic [2*N-1:0]  ebe;
        logic [DW-1:0]   a;
        longint          mx;
        logic [N-1:0]    ew;
        int              len;

        vt[0]  = '{4'd0, 32'd0,    2'd0, 1'b0, 3'd0, 1'b0};
        vt[1]  = '{4'd1, 32'd0,    2'd0, 1'b0, 3'd2, 1'b0};
        vt[2]  = '{4'd9, 32'd0,    2'd0, 1'b0, 3'd4, 1'b0};
        vt[3]  = '{4'd3, 32'd100,  2'd0, 1'b0, 3'd0, 1'b0};
        vt[4]  = '{4'd3, 32'd200,  2'd1, 1'b0, 3'd0, 1'b0};
        vt[5]  = '{4'd3, 32'd50,   2'd2, 1'b0, 3'd0, 1'b0};
        vt[6]  = '{4'd3, 32'd10,   2'd3, 1'b0, 3'd0, 1'b0};
        vt[7]  = '{4'd2, 32'h77,   2'd0, 1'b1, 3'd3, 1'b0};
        vt[8]  = '{4'd2, 32'hA5,   2'd0, 1'b0, 3'd0, 1'b1};
        vt[9]  = '{4'd2, 32'h33,   2'd0, 1'b0, 3'd5, 1'b1};
        vt[10] = '{4'd3, 32'd999,  2'd0, 1'b0, 3'd4, 1'b1};
        vt[11] = '{4'd4, 32'd0,    2'd0, 1'b0, 3'd4, 1'b1};
        vt[12] = '{4'd6, 32'd9,    2'd0, 1'b0, 3'd4, 1'b1};
        vt[13] = '{4'd7, 32'd0,    2'd0, 1'b0, 3'd4, 1'b1};
        vt[14] = '{4'd0, 32'd0,    2'd0, 1'b0, 3'd0, 1'b1};

        reset = 1'b1;
        idle();
        op5 = 4'd0; data5 = '0; addr5 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_err", err, 0);
        chk("rst_roundOver", roundOver, 0);
        chk("rst_maxBid", maxBid, 0);
        chk("rst_win", win, 0);
        chk("rst_balance", balance, 0);
        chk("rst_bidErr", bidErr, 0);
        reset = 1'b0;
        step();

        // out-of-range LOAD address on the five-bidder instance
        op5 = 4'd3; addr5 = 3'd5; data5 = 32'd77;
        step();
        chk("n5_load_addr5_err", err5, 4);
        chk("n5_load_addr5_nowrite", balance5, 0);
        addr5 = 3'd4;
        step();
        chk("n5_load_addr4_err", err5, 0);
        chk("n5_load_addr4_bal", balance5[4*DW +: DW], 77);
        op5 = 4'd0;

        for (int i = 0; i < 15; i++) begin
            C_op = vt[i].op; C_data = vt[i].data; C_addr = vt[i].addr; C_start = vt[i].cs;
            step();
            chk($sformatf("vec%0d_err", i), err, vt[i].e_err);
            chk($sformatf("vec%0d_ready", i), ready, vt[i].e_rdy);
            idle();
        end
        chk("loaded_balances", balance, {32'd10, 32'd50, 32'd200, 32'd100});

        // round 1: bidder3 needs 11 but holds 10
        start_round("r1");
        bid_cycle(4'b1011, 4'b0000, {32'd10, 32'd0, 32'd60, 32'd40});
        chk("r1_bidErr", bidErr, 8'h40);
        chk("r1_balance", balance, {32'd10, 32'd50, 32'd139, 32'd59});
        end_round(32'd60, 4'b0010, "r1");

        // round 2: tie goes to the lower index
        start_round("r2");
        bid_cycle(4'b0110, 4'b0000, {32'd0, 32'd20, 32'd20, 32'd0});
        chk("r2_bidErr", bidErr, 0);
        chk("r2_balance", balance, {32'd10, 32'd29, 32'd118, 32'd59});
        end_round(32'd20, 4'b0010, "r2");

        // round 3: tie again, then bidder1 retracts
        start_round("r3");
        bid_cycle(4'b0110, 4'b0000, {32'd0, 32'd20, 32'd20, 32'd0});
        bid_cycle(4'b0000, 4'b0010, '0);
        chk("r3_balance", balance, {32'd10, 32'd8, 32'd97, 32'd59});
        end_round(32'd20, 4'b0100, "r3");

        // masked bidder
        cop(4'd1, 32'hA5, 2'd0, 3'd0, "unlock_a5");
        chk("unlock_a5_ready", ready, 0);
        cop(4'd4, 32'b1101, 2'd0, 3'd0, "setmask");
        cop(4'd2, 32'hA5, 2'd0, 3'd0, "relock_a5");
        start_round("r4");
        bid_cycle(4'b0010, 4'b0000, {32'd0, 32'd0, 32'd5, 32'd0});
        chk("r4_bidErr_invalid", bidErr, 8'h08);
        chk("r4_balance_same", balance, {32'd10, 32'd8, 32'd97, 32'd59});
        end_round(32'd0, 4'b0000, "r4");

        // cooldown with timer 3, then timer 0
        cop(4'd1, 32'hA5, 2'd0, 3'd0, "unlock_a5b");
        cop(4'd5, 32'd3, 2'd0, 3'd0, "settimer3");
        cop(4'd2, 32'h1, 2'd0, 3'd0, "lock_1");
        cooldown(32'h2, 4, "cd3");
        cop(4'd1, 32'h1, 2'd0, 3'd0, "unlock_1");
        chk("unlock_1_ready", ready, 0);
        cop(4'd5, 32'd0, 2'd0, 3'd0, "settimer0");
        cop(4'd2, 32'h7, 2'd0, 3'd0, "lock_7");
        cooldown(32'h8, 1, "cd0");
        cop(4'd1, 32'h7, 2'd0, 3'd0, "unlock_7");

        // reset in the middle of a round
        cop(4'd2, 32'h5A, 2'd0, 3'd0, "lock_5a");
        C_start = 1'b1;
        step();
        bid_cycle(4'b1000, 4'b0000, {32'd50, 32'd0, 32'd0, 32'd0});
        chk("pre_rst_bidErr", bidErr, 8'h40);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_roundOver", roundOver, 0);
        chk("mid_rst_maxBid", maxBid, 0);
        chk("mid_rst_win", win, 0);
        chk("mid_rst_balance", balance, 0);
        chk("mid_rst_bidErr", bidErr, 0);
        idle();
        @(negedge clk);
        reset = 1'b0;
        C_start = 1'b1;
        step();
        chk("post_rst_cstart_unlocked", err, 3);
        C_start = 1'b0;
        cop(4'd3, 32'd100, 2'd0, 3'd0, "post_rst_load");
        cop(4'd2, 32'h42, 2'd0, 3'd0, "post_rst_lock");
        chk("post_rst_ready", ready, 1);
        start_round("r5");
        bid_cycle(4'b0011, 4'b0000, {32'd0, 32'd0, 32'd0, 32'd10});
        chk("r5_bidErr", bidErr, 8'h04);
        chk("r5_balance", balance, {32'd0, 32'd0, 32'd0, 32'd89});
        end_round(32'd10, 4'b0001, "r5");
        cooldown(32'h43, 16, "cd_default");
        cop(4'd1, 32'h42, 2'd0, 3'd0, "unlock_42");

        // randomized rounds against the round-level model
        for (int r = 0; r < 25; r++) begin
            m_charge = $urandom_range(0, 4);
            cop(4'd6, DW'(m_charge), 2'd0, 3'd0, $sformatf("rnd%0d_charge", r));
            m_mask = (r < 3) ? 4'hF : N'($urandom_range(0, 15));
            cop(4'd4, DW'(m_mask), 2'd0, 3'd0, $sformatf("rnd%0d_mask", r));
            for (int i = 0; i < N; i++) begin
                m_bal[i]  = $urandom_range(0, 400);
                m_last[i] = 0;
                cop(4'd3, DW'(m_bal[i]), IW'(i), 3'd0, $sformatf("rnd%0d_load%0d", r, i));
            end
            key = $urandom;
            cop(4'd2, key, 2'd0, 3'd0, $sformatf("rnd%0d_lock", r));
            start_round($sformatf("rnd%0d", r));
            len = $urandom_range(1, 4);
            for (int c = 0; c < len; c++) begin
                ebe = '0;
                for (int i = 0; i < N; i++) begin
                    bv[i] = ($urandom_range(0, 1) == 1);
                    rv[i] = ($urandom_range(0, 3) == 0);
                    a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                                    : DW'($urandom_range(0, 200));
                    amts[i*DW +: DW] = a;
                    if (bv[i]) begin
                        if (!m_mask[i]) begin
                            ebe[i*2 +: 2] = 2'd2;
                        end else if (longint'(a) + m_charge > m_bal[i]) begin
                            ebe[i*2 +: 2] = 2'd1;
                        end else begin
                            m_bal[i]  = m_bal[i] - (longint'(a) + m_charge);
                            m_last[i] = longint'(a);
                        end
                    end else if (rv[i]) begin
                        m_last[i] = 0;
                    end
                end
                bid_cycle(bv, rv, amts);
                for (int i = 0; i < N; i++) ebal[i*DW +: DW] = DW'(m_bal[i]);
                chk($sformatf("rnd%0d_c%0d_bidErr", r, c), bidErr, ebe);
                chk($sformatf("rnd%0d_c%0d_balance", r, c), balance, ebal);
            end
            mx = 0;
            for (int i = 0; i < N; i++) if (m_last[i] > mx) mx = m_last[i];
            ew = '0;
            if (mx != 0) begin
                for (int i = N - 1; i >= 0; i--) if (m_last[i] == mx) ew = N'(1) << i;
            end
            end_round(DW'(mx), ew, $sformatf("rnd%0d", r));
            cop(4'd1, key, 2'd0, 3'd0, $sformatf("rnd%0d_unlock", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
